id_decode_pipe: RTL and testbench

Parametrised instruction-decode stage for the MIPS core: a 32-entry register file and a field/control decoder behind one pipeline register with a valid/ready handshake. It accepts one 32-bit instruction per cycle from fetch and presents operands, extended immediate, shift amount, destination and control one cycle later. The writeback stage writes results back through a dedicated write port. Generalises the fixed-width, unregistered decode+regfile join with data width, stall handling, writeback forwarding and illegal-opcode detection.

---
 rtl/id_decode_pipe_if.sv | 37 +++
 rtl/id_decode_pipe.sv | 178 +++++++++++++++++
 tb/tb_id_decode_pipe.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/id_decode_pipe_if.sv
// Fetch/decode/execute/writeback signal bundle for the instruction-decode stage.
// slave = decode stage view, master = surrounding pipeline view.
interface id_decode_pipe_if #(
   parameter int unsigned DATA_W = 32
) ();
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       ins;
   logic              wb_we;
   logic [4:0]        wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              out_valid;
   logic              out_ready;
   logic [5:0]        op;
   logic [5:0]        func;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        dst;
   logic [4:0]        shamt;
   logic [DATA_W-1:0] rdata1;
   logic [DATA_W-1:0] rdata2;
   logic [DATA_W-1:0] ed;
   logic              reg_we;
   logic              illegal;

   modport slave (
      input  in_valid, ins, wb_we, wb_addr, wb_data, out_ready,
      output in_ready, out_valid, op, func, rs, rt, dst, shamt,
             rdata1, rdata2, ed, reg_we, illegal
   );

   modport master (
      output in_valid, ins, wb_we, wb_addr, wb_data, out_ready,
      input  in_ready, out_valid, op, func, rs, rt, dst, shamt,
             rdata1, rdata2, ed, reg_we, illegal
   );
endinterface

// File: rtl/id_decode_pipe.sv
// MIPS instruction-decode stage: 32-entry register file, field/control decoder, one output register.
// Optional macro ID_BYPASS_EN forwards same-cycle writeback data into read operands.
module id_decode_pipe #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned JAL_REG = 31
) (
   input  logic            i_clk,
   input  logic            i_rst,
   id_decode_pipe_if.slave bus
);
   localparam int unsigned NREG = 32;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   logic [DATA_W-1:0] r_regs [NREG];

   logic              r_out_valid;
   logic [5:0]        r_op;
   logic [5:0]        r_func;
   logic [4:0]        r_rs;
   logic [4:0]        r_rt;
   logic [4:0]        r_dst;
   logic [4:0]        r_shamt;
   logic [DATA_W-1:0] r_rdata1;
   logic [DATA_W-1:0] r_rdata2;
   logic [DATA_W-1:0] r_ed;
   logic              r_reg_we;
   logic              r_illegal;

   logic              w_in_ready;
   logic              w_accept;
   logic [5:0]        w_op;
   logic [5:0]        w_func;
   logic [4:0]        w_rs;
   logic [4:0]        w_rt;
   logic [4:0]        w_rd;
   logic [4:0]        w_shamt;
   logic [15:0]       w_imm;
   logic [4:0]        w_dst;
   logic [DATA_W-1:0] w_ed;
   logic              w_reg_we;
   logic              w_illegal;
   logic [DATA_W-1:0] w_rdata1;
   logic [DATA_W-1:0] w_rdata2;

   assign w_in_ready = !r_out_valid || bus.out_ready;
   assign w_accept   = bus.in_valid && w_in_ready;

   assign w_op    = bus.ins[31:26];
   assign w_rs    = bus.ins[25:21];
   assign w_rt    = bus.ins[20:16];
   assign w_rd    = bus.ins[15:11];
   assign w_shamt = bus.ins[10:6];
   assign w_func  = bus.ins[5:0];
   assign w_imm   = bus.ins[15:0];

   // Control decode: destination, write enable, immediate extension, legality
   always_comb begin
      w_illegal = 1'b0;
      w_reg_we  = 1'b0;
      w_dst     = w_rt;
      w_ed      = DATA_W'($signed(w_imm));
      case (w_op)
         OP_R: begin
            w_dst    = w_rd;
            w_reg_we = (w_func != FN_JR);
         end
         OP_JAL: begin
            w_dst    = 5'(JAL_REG);
            w_reg_we = 1'b1;
         end
         OP_J, OP_BEQ, OP_BNE, OP_SW: begin
            w_reg_we = 1'b0;
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_LW: begin
            w_reg_we = 1'b1;
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            w_reg_we = 1'b1;
            w_ed     = DATA_W'(w_imm);
         end
         OP_LUI: begin
            w_reg_we = 1'b1;
            w_ed     = DATA_W'({w_imm, 16'h0000});
         end
         default: begin
            w_illegal = 1'b1;
            w_dst     = 5'd0;
         end
      endcase
   end

   // Register read ports; R0 is hard zero
   always_comb begin
      w_rdata1 = (w_rs == 5'd0) ? '0 : r_regs[w_rs];
      w_rdata2 = (w_rt == 5'd0) ? '0 : r_regs[w_rt];
`ifdef ID_BYPASS_EN
      if (bus.wb_we && (bus.wb_addr == w_rs) && (w_rs != 5'd0)) w_rdata1 = bus.wb_data;
      if (bus.wb_we && (bus.wb_addr == w_rt) && (w_rt != 5'd0)) w_rdata2 = bus.wb_data;
`endif
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else if (bus.wb_we && (bus.wb_addr != 5'd0)) begin
         r_regs[bus.wb_addr] <= bus.wb_data;
      end
   end

   // Output pipeline register with valid/ready handshake
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_out_valid <= 1'b0;
         r_op        <= '0;
         r_func      <= '0;
         r_rs        <= '0;
         r_rt        <= '0;
         r_dst       <= '0;
         r_shamt     <= '0;
         r_rdata1    <= '0;
         r_rdata2    <= '0;
         r_ed        <= '0;
         r_reg_we    <= 1'b0;
         r_illegal   <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_op        <= w_op;
         r_func      <= w_func;
         r_rs        <= w_rs;
         r_rt        <= w_rt;
         r_dst       <= w_dst;
         r_shamt     <= w_shamt;
         r_rdata1    <= w_rdata1;
         r_rdata2    <= w_rdata2;
         r_ed        <= w_ed;
         r_reg_we    <= w_reg_we;
         r_illegal   <= w_illegal;
      end else if (r_out_valid && bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
`ifdef ID_BYPASS_EN
      else if (r_out_valid) begin
         // Stalled: keep held operands coherent with writeback
         if (bus.wb_we && (bus.wb_addr == r_rs) && (r_rs != 5'd0)) r_rdata1 <= bus.wb_data;
         if (bus.wb_we && (bus.wb_addr == r_rt) && (r_rt != 5'd0)) r_rdata2 <= bus.wb_data;
      end
`endif
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.op        = r_op;
   assign bus.func      = r_func;
   assign bus.rs        = r_rs;
   assign bus.rt        = r_rt;
   assign bus.dst       = r_dst;
   assign bus.shamt     = r_shamt;
   assign bus.rdata1    = r_rdata1;
   assign bus.rdata2    = r_rdata2;
   assign bus.ed        = r_ed;
   assign bus.reg_we    = r_reg_we;
   assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_id_decode_pipe.sv
// Directed bench for id_decode_pipe: decode fields, register file, stall, forwarding, reset.
module tb_id_decode_pipe;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   id_decode_pipe_if #(.DATA_W(32)) bus ();

   id_decode_pipe #(.DATA_W(32), .JAL_REG(31)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
      bus.wb_we   = we;
      bus.wb_addr = a;
      bus.wb_data = d;
   endtask

   logic [31:0] exp_stall_rd1;
   logic [31:0] exp_byp_rd1;

   initial begin
`ifdef ID_BYPASS_EN
      exp_stall_rd1 = 32'h0000_0099;
      exp_byp_rd1   = 32'h0000_0077;
`else
      exp_stall_rd1 = 32'h0000_00AA;
      exp_byp_rd1   = 32'h0000_0099;
`endif
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.ins       = '0;
      bus.out_ready = 1'b1;
      wb(1'b0, 5'd0, 32'h0);
      tick();
      rst = 1'b0;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_ed",        bus.ed,             32'h0);

      wb(1'b1, 5'd10, 32'h0000_00AA);
      tick();
      wb(1'b1, 5'd11, 32'h8000_0001);
      tick();
      wb(1'b0, 5'd0, 32'h0);

      bus.in_valid = 1'b1;
      bus.ins = {6'd0, 5'd10, 5'd11, 5'd9, 5'd5, 6'd0};
      tick();
      chk("sll_valid",   32'(bus.out_valid), 32'd1);
      chk("sll_dst",     32'(bus.dst),       32'd9);
      chk("sll_shamt",   32'(bus.shamt),     32'd5);
      chk("sll_rdata1",  bus.rdata1,         32'h0000_00AA);
      chk("sll_rdata2",  bus.rdata2,         32'h8000_0001);
      chk("sll_reg_we",  32'(bus.reg_we),    32'd1);
      chk("sll_illegal", 32'(bus.illegal),   32'd0);

      bus.ins = {6'b001101, 5'd0, 5'd3, 16'hFFFF};
      tick();
      chk("ori_ed",  bus.ed,         32'h0000_FFFF);
      chk("ori_dst", 32'(bus.dst),   32'd3);

      bus.ins = {6'b001000, 5'd0, 5'd4, 16'hFFFF};
      tick();
      chk("addi_ed", bus.ed, 32'hFFFF_FFFF);

      bus.ins = {6'b001111, 5'd0, 5'd5, 16'h1234};
      wb(1'b1, 5'd0, 32'h0000_0055);
      tick();
      wb(1'b0, 5'd0, 32'h0);
      chk("lui_ed", bus.ed, 32'h1234_0000);

      bus.ins = {6'd0, 5'd0, 5'd10, 5'd1, 5'd0, 6'b100001};
      tick();
      chk("r0_rdata1", bus.rdata1, 32'h0);
      chk("r0_rdata2", bus.rdata2, 32'h0000_00AA);
      chk("r0_dst",    32'(bus.dst), 32'd1);

      bus.ins = {6'b101011, 5'd10, 5'd11, 16'h0004};
      tick();
      chk("sw_reg_we",  32'(bus.reg_we),  32'd0);
      chk("sw_illegal", 32'(bus.illegal), 32'd0);
      chk("sw_ed",      bus.ed,           32'h0000_0004);

      bus.ins = {6'b000100, 5'd10, 5'd11, 16'h8000};
      tick();
      chk("beq_reg_we", 32'(bus.reg_we), 32'd0);
      chk("beq_ed",     bus.ed,          32'hFFFF_8000);

      bus.ins = {6'h3F, 5'd1, 5'd2, 16'h0000};
      tick();
      chk("ill_illegal", 32'(bus.illegal), 32'd1);
      chk("ill_reg_we",  32'(bus.reg_we),  32'd0);
      chk("ill_dst",     32'(bus.dst),     32'd0);

      bus.ins = {6'b000011, 26'h000_0010};
      tick();
      chk("jal_dst",     32'(bus.dst),     32'd31);
      chk("jal_reg_we",  32'(bus.reg_we),  32'd1);
      chk("jal_illegal", 32'(bus.illegal), 32'd0);

      bus.ins = {6'd0, 5'd10, 5'd0, 5'd0, 5'd0, 6'b001000};
      tick();
      chk("jr_reg_we",  32'(bus.reg_we),  32'd0);
      chk("jr_illegal", 32'(bus.illegal), 32'd0);

      bus.ins = {6'b001100, 5'd10, 5'd6, 16'h8001};
      tick();
      chk("andi_ed",     bus.ed,       32'h0000_8001);
      chk("andi_rdata1", bus.rdata1,   32'h0000_00AA);

      // Stall for three cycles with a new instruction offered and a writeback to held rs
      bus.out_ready = 1'b0;
      bus.ins = {6'b001110, 5'd10, 5'd7, 16'h8000};
      wb(1'b1, 5'd10, 32'h0000_0099);
      tick();
      wb(1'b0, 5'd0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         chk("stall_valid",    32'(bus.out_valid), 32'd1);
         chk("stall_in_ready", 32'(bus.in_ready),  32'd0);
         chk("stall_dst",      32'(bus.dst),       32'd6);
         chk("stall_ed",       bus.ed,             32'h0000_8001);
         chk("stall_rdata1",   bus.rdata1,         exp_stall_rd1);
         if (i < 2) tick();
      end
      bus.out_ready = 1'b1;
      #1;
      chk("unstall_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      chk("xori_dst",    32'(bus.dst), 32'd7);
      chk("xori_ed",     bus.ed,       32'h0000_8000);
      chk("xori_rdata1", bus.rdata1,   32'h0000_0099);

      bus.ins = {6'b001001, 5'd10, 5'd8, 16'h0001};
      wb(1'b1, 5'd10, 32'h0000_0077);
      tick();
      wb(1'b0, 5'd0, 32'h0);
      chk("byp_rdata1", bus.rdata1, exp_byp_rd1);
      chk("byp_dst",    32'(bus.dst), 32'd8);

      bus.in_valid = 1'b0;
      tick();
      chk("drain_valid", 32'(bus.out_valid), 32'd0);

      bus.in_valid = 1'b1;
      bus.ins = {6'd0, 5'd10, 5'd11, 5'd2, 5'd0, 6'b100000};
      tick();
      chk("r10_after_wb", bus.rdata1, 32'h0000_0077);

      // Reset in the middle of a stall
      bus.out_ready = 1'b0;
      bus.ins = {6'b001101, 5'd11, 5'd12, 16'h00F0};
      tick();
      chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_valid",   32'(bus.out_valid), 32'd0);
      chk("mrst_dst",     32'(bus.dst),       32'd0);
      chk("mrst_op",      32'(bus.op),        32'd0);
      chk("mrst_rdata1",  bus.rdata1,         32'h0);
      chk("mrst_ed",      bus.ed,             32'h0);
      chk("mrst_reg_we",  32'(bus.reg_we),    32'd0);

      bus.out_ready = 1'b1;
      bus.ins = {6'd0, 5'd10, 5'd11, 5'd2, 5'd0, 6'b100000};
      tick();
      chk("post_rst_valid",  32'(bus.out_valid), 32'd1);
      chk("post_rst_rdata1", bus.rdata1,         32'h0);
      chk("post_rst_rdata2", bus.rdata2,         32'h0);

      bus.in_valid = 1'b0;
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
